writeback_arbiter: RTL and testbench

Writeback stage that merges single-cycle ALU results and variable-latency load returns onto the single write port of the 16×32 processor register file. Keeps a 16-bit load scoreboard that drives the operand-read hazard signal for the decode/read stage, and buffers load returns in a small FIFO. Sits between execute/memory and the register file write inputs (RD, WD, wr_enable).

---
 rtl/writeback_arbiter.sv | 170 +++++++++++++++++
 tb/tb_writeback_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//   Merges single-cycle ALU results and variable-latency load returns onto the
//   single write port of a 16x32 register file. A 16-bit load scoreboard drives
//   the operand-read hazard signal, and load returns are buffered in a FIFO.
//
//   Optional feature macro: WB_BYPASS_EN
//     When defined, a load return that arrives while the FIFO is empty and no
//     ALU result is presented skips the FIFO and loads the output register
//     directly (one cycle shorter load latency).
//
//   Ports
//     clk, rst                 clock, asynchronous active-low reset
//     alu_valid/alu_rd/alu_data  ALU result in; alu_hold out (registered)
//     mem_valid/mem_rd/mem_data  load return in; mem_ready out (!full)
//     issue_load/issue_rd      load issue, sets scoreboard bit
//     rs1, rs2, rs3            operand addresses; hazard out (combinational)
//     rf_we/rf_rd/rf_wd        registered register-file write port
//     err                      sticky protocol-violation flag
module writeback_arbiter #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [3:0]        alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_hold,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [3:0]        mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              issue_load,
  input  logic [3:0]        issue_rd,
  input  logic [3:0]        rs1,
  input  logic [3:0]        rs2,
  input  logic [3:0]        rs3,
  output logic              hazard,
  output logic              rf_we,
  output logic [3:0]        rf_rd,
  output logic [DATA_W-1:0] rf_wd,
  output logic              err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [3:0]        fifo_rd   [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [15:0]       pending_q, pending_d;
  logic              hold_q, hold_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [3:0]        rd_q, rd_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              wb_load_q, wb_load_d;  // output register holds a load result

  logic empty, full, push, fifo_push, pop, bypass, alu_accept, alu_win;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CW'(FIFO_DEPTH));
  assign mem_ready = rst & ~full;
  assign push      = mem_valid & mem_ready;

  // A result presented under hold is dropped (and flagged) rather than arbitrated.
  assign alu_accept = alu_valid & ~hold_q;
  assign alu_win    = alu_accept & (starve_q < SW'(STARVE_MAX));
  assign pop        = ~alu_win & ~empty;

`ifdef WB_BYPASS_EN
  assign bypass = push & empty & ~alu_valid;
`else
  assign bypass = 1'b0;
`endif
  assign fifo_push = push & ~bypass;

  always_comb begin
    we_d      = 1'b0;
    rd_d      = rd_q;
    wd_d      = wd_q;
    wb_load_d = 1'b0;
    if (alu_win) begin
      we_d = (alu_rd != 4'd0);
      rd_d = alu_rd;
      wd_d = alu_data;
    end else if (pop) begin
      we_d      = (fifo_rd[rptr_q] != 4'd0);
      rd_d      = fifo_rd[rptr_q];
      wd_d      = fifo_data[rptr_q];
      wb_load_d = 1'b1;
    end else if (bypass) begin
      we_d      = (mem_rd != 4'd0);
      rd_d      = mem_rd;
      wd_d      = mem_data;
      wb_load_d = 1'b1;
    end

    wptr_d = fifo_push ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop ? rptr_q + AW'(1) : rptr_q;
    cnt_d  = cnt_q + CW'(fifo_push) - CW'(pop);

    // Counts only ALU wins that bypass a waiting load; any pop or an empty FIFO clears it.
    starve_d = (alu_win && !empty) ? starve_q + SW'(1) : '0;
    hold_d   = (starve_d == SW'(STARVE_MAX)) || (cnt_d == CW'(FIFO_DEPTH));

    // Clear first so a same-edge set on the same register wins.
    pending_d = pending_q;
    if (we_q && wb_load_q)
      pending_d[rd_q] = 1'b0;
    if (issue_load && issue_rd != 4'd0)
      pending_d[issue_rd] = 1'b1;

    err_d = err_q;
    if (issue_load && issue_rd != 4'd0 && pending_q[issue_rd]) err_d = 1'b1;
    if (alu_accept && alu_rd != 4'd0 && pending_q[alu_rd])     err_d = 1'b1;
    if (push && mem_rd != 4'd0 && !pending_q[mem_rd])          err_d = 1'b1;
    if (alu_valid && hold_q)                                   err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      starve_q  <= '0;
      pending_q <= '0;
      hold_q    <= 1'b0;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
      rd_q      <= '0;
      wd_q      <= '0;
      wb_load_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      starve_q  <= starve_d;
      pending_q <= pending_d;
      hold_q    <= hold_d;
      err_q     <= err_d;
      we_q      <= we_d;
      rd_q      <= rd_d;
      wd_q      <= wd_d;
      wb_load_q <= wb_load_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_rd[wptr_q]   <= mem_rd;
      fifo_data[wptr_q] <= mem_data;
    end
  end

  assign hazard = (rs1 != 4'd0 && pending_q[rs1]) ||
                  (rs2 != 4'd0 && pending_q[rs2]) ||
                  (rs3 != 4'd0 && pending_q[rs3]);

  assign alu_hold = hold_q;
  assign err      = err_q;
  assign rf_we    = we_q;
  assign rf_rd    = rd_q;
  assign rf_wd    = wd_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid, issue_load;
  logic [3:0]  alu_rd, mem_rd, issue_rd, rs1, rs2, rs3;
  logic [31:0] alu_data, mem_data;
  logic        alu_hold, mem_ready, hazard, rf_we, err;
  logic [3:0]  rf_rd;
  logic [31:0] rf_wd;

  int checks   = 0;
  int failures = 0;

  writeback_arbiter #(.DATA_W(32), .FIFO_DEPTH(4), .STARVE_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_hold(alu_hold),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .issue_load(issue_load), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .rs3(rs3), .hazard(hazard),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;  logic [3:0] ard; logic [31:0] adata;
    logic        mv;  logic [3:0] mrd; logic [31:0] mdata;
    logic        il;  logic [3:0] ird; logic [3:0]  r1;
    logic        e_we; logic [3:0] e_rd; logic [31:0] e_wd;
    logic        e_hz; logic e_rdy; logic e_hold; logic e_err;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    issue_load = 0; issue_rd = 0;
    rs1 = 0; rs2 = 0; rs3 = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int found;
    idle_inputs();
    rst = 1'b0;

    //            av ard adata         mv mrd mdata        il ird r1  we rd wd            hz rdy hold err
    vt[0] = '{1, 5, 32'hDEADBEEF, 0, 0, 0,            0, 0, 0,  1, 5, 32'hDEADBEEF, 0, 1, 0, 0};
    vt[1] = '{0, 0, 0,            0, 0, 0,            1, 3, 3,  0, 5, 32'hDEADBEEF, 1, 1, 0, 0};
`ifdef WB_BYPASS_EN
    vt[2] = '{0, 0, 0,            1, 3, 32'h1234,     0, 0, 3,  1, 3, 32'h1234,     1, 1, 0, 0};
    vt[3] = '{0, 0, 0,            0, 0, 0,            0, 0, 3,  0, 3, 32'h1234,     0, 1, 0, 0};
`else
    vt[2] = '{0, 0, 0,            1, 3, 32'h1234,     0, 0, 3,  0, 5, 32'hDEADBEEF, 1, 1, 0, 0};
    vt[3] = '{0, 0, 0,            0, 0, 0,            0, 0, 3,  1, 3, 32'h1234,     1, 1, 0, 0};
`endif
    vt[4] = '{0, 0, 0,            0, 0, 0,            0, 0, 3,  0, 3, 32'h1234,     0, 1, 0, 0};
    vt[5] = '{1, 0, 32'hFFFFFFFF, 0, 0, 0,            0, 0, 0,  0, 0, 32'hFFFFFFFF, 0, 1, 0, 0};
    vt[6] = '{0, 0, 0,            0, 0, 0,            1, 0, 0,  0, 0, 32'hFFFFFFFF, 0, 1, 0, 0};
    vt[7] = '{1, 6, 32'h600D,     0, 0, 0,            0, 0, 0,  1, 6, 32'h600D,     0, 1, 0, 0};

    // Reset state
    rs1 = 3;
    tick(); tick();
    chk("rst_we", 32'(rf_we), 0);
    chk("rst_rd", 32'(rf_rd), 0);
    chk("rst_wd", rf_wd, 0);
    chk("rst_hold", 32'(alu_hold), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_ready", 32'(mem_ready), 0);
    chk("rst_hazard", 32'(hazard), 0);
    rst = 1'b1;
    idle_inputs();
    tick();
    chk("post_rst_ready", 32'(mem_ready), 1);

    for (int i = 0; i < 8; i++) begin
      alu_valid = vt[i].av; alu_rd = vt[i].ard; alu_data = vt[i].adata;
      mem_valid = vt[i].mv; mem_rd = vt[i].mrd; mem_data = vt[i].mdata;
      issue_load = vt[i].il; issue_rd = vt[i].ird; rs1 = vt[i].r1;
      tick();
      chk($sformatf("v%0d_we", i),    32'(rf_we),     32'(vt[i].e_we));
      chk($sformatf("v%0d_rd", i),    32'(rf_rd),     32'(vt[i].e_rd));
      chk($sformatf("v%0d_wd", i),    rf_wd,          vt[i].e_wd);
      chk($sformatf("v%0d_hz", i),    32'(hazard),    32'(vt[i].e_hz));
      chk($sformatf("v%0d_rdy", i),   32'(mem_ready), 32'(vt[i].e_rdy));
      chk($sformatf("v%0d_hold", i),  32'(alu_hold),  32'(vt[i].e_hold));
      chk($sformatf("v%0d_err", i),   32'(err),       32'(vt[i].e_err));
    end
    idle_inputs();

    // FIFO fill to full under continuous ALU traffic, then drain
    for (int r = 8; r < 12; r++) begin
      issue_load = 1; issue_rd = 4'(r);
      tick();
    end
    issue_load = 0; issue_rd = 0; rs1 = 11;
    for (int r = 8; r < 12; r++) begin
      alu_valid = ~alu_hold; alu_rd = 1; alu_data = 32'(r);
      mem_valid = 1; mem_rd = 4'(r); mem_data = 32'hA000 + 32'(r);
      tick();
      chk($sformatf("fill%0d_ready", r), 32'(mem_ready), (r == 11) ? 0 : 1);
      chk($sformatf("fill%0d_hold", r),  32'(alu_hold),  (r == 11) ? 1 : 0);
      chk($sformatf("fill%0d_alu", r),   rf_wd,          32'(r));
    end
    mem_valid = 0; alu_valid = 0;
    for (int r = 8; r < 12; r++) begin
      tick();
      chk($sformatf("drain%0d_we", r), 32'(rf_we), 1);
      chk($sformatf("drain%0d_rd", r), 32'(rf_rd), 32'(r));
      chk($sformatf("drain%0d_wd", r), rf_wd,      32'hA000 + 32'(r));
      chk($sformatf("drain%0d_ready", r), 32'(mem_ready), 1);
      chk($sformatf("drain%0d_hold", r),  32'(alu_hold),  0);
    end
    chk("drain_hazard_before_write", 32'(hazard), 1);
    tick();
    chk("drain_idle_we", 32'(rf_we), 0);
    chk("drain_hazard_after_write", 32'(hazard), 0);
    chk("drain_err", 32'(err), 0);

    // Starvation bound: ALU on every allowed cycle with one queued load
    issue_load = 1; issue_rd = 12; rs1 = 0;
    tick();
    issue_load = 0; issue_rd = 0;
    alu_valid = 1; alu_rd = 1; alu_data = 32'h55;
    mem_valid = 1; mem_rd = 12; mem_data = 32'hBEEF0012;
    tick();
    mem_valid = 0;
    found = 0;
    for (int n = 1; n <= 15 && found == 0; n++) begin
      alu_valid = ~alu_hold;
      tick();
      if (rf_we && rf_rd == 4'd12) found = n;
    end
    chk("starve_pop_cycle", 32'(found), 9);
    chk("starve_wd", rf_wd, 32'hBEEF0012);
    chk("starve_err", 32'(err), 0);
    idle_inputs();
    tick();

    // Double issue to the same register sets sticky err
    issue_load = 1; issue_rd = 7;
    tick();
    chk("dbl_issue_first_err", 32'(err), 0);
    tick();
    chk("dbl_issue_err", 32'(err), 1);
    idle_inputs();
    tick(); tick(); tick();
    chk("err_sticky", 32'(err), 1);

    // Reset pulse with a load sitting in the FIFO
    issue_load = 1; issue_rd = 13;
    tick();
    issue_load = 0; issue_rd = 0;
    alu_valid = 1; alu_rd = 1; alu_data = 32'h77;
    mem_valid = 1; mem_rd = 13; mem_data = 32'h13;
    tick();
    idle_inputs();
    rs1 = 13;
    #2 rst = 1'b0;
    #1;
    chk("midrst_ready", 32'(mem_ready), 0);
    chk("midrst_err", 32'(err), 0);
    chk("midrst_hazard", 32'(hazard), 0);
    chk("midrst_we", 32'(rf_we), 0);
    tick();
    rst = 1'b1;
    tick();
    chk("after_rst_ready", 32'(mem_ready), 1);
    chk("after_rst_we", 32'(rf_we), 0);
    chk("after_rst_hazard", 32'(hazard), 0);
    chk("after_rst_err", 32'(err), 0);

    // Load return with no matching issue
    mem_valid = 1; mem_rd = 4; mem_data = 32'h4;
    tick();
    mem_valid = 0;
    chk("stray_return_err", 32'(err), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
